// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and helpers for the serial pattern detector
package seq_det_pkg;

  localparam logic OVERLAP     = 1'b1;
  localparam logic NON_OVERLAP = 1'b0;

  localparam logic [3:0] DEF_PAT_1101 = 4'b1101;

  // Elaboration-time ceil(log2); the loop stops at 31 because PAT_W never exceeds 32.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_hist_shift.sv
// rtl/seq_hist_shift.sv - history shift register and fill counter of accepted serial bits
module seq_hist_shift
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             flush,
  output logic [PAT_W-2:0] hist,
  output logic             full
);

  localparam int FILL_W = clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  // Flush beats shift: a flushed cycle leaves an empty history, not one holding bit_in.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (flush) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hist_d = (PAT_W-1)'({hist_q, bit_in});
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist = hist_q;
  assign full = (fill_q == FILL_MAX);

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - run-time loadable serial pattern detector with match counter
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(DEF_PAT_1101),
  parameter int               CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  input  logic             overlap_en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             detect,
  output logic             detect_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic [PAT_W-1:0] pattern
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             det_q;
  logic [PAT_W-2:0] hist;
  logic             full;
  logic             accept;
  logic             flush;

  seq_hist_shift #(
    .PAT_W (PAT_W)
  ) u_hist (
    .clk      (clk),
    .reset    (reset),
    .shift_en (accept),
    .bit_in   (din),
    .flush    (flush),
    .hist     (hist),
    .full     (full)
  );

  // A pattern load discards the bit on din in the same cycle and restarts the history.
  always_comb begin
    accept = din_valid & ~pat_load;
    detect = ~reset & accept & full & ({hist, din} == pat_q);
    flush  = pat_load | (detect & (overlap_en == NON_OVERLAP));
    pat_d  = pat_load ? pat_in : pat_q;
    cnt_d  = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (detect && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q <= PAT_INIT;
      cnt_q <= '0;
      det_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      cnt_q <= cnt_d;
      det_q <= detect;
    end
  end

  assign detect_q  = det_q;
  assign match_cnt = cnt_q;
  assign pattern   = pat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed self-checking bench for seq_detector_param
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       overlap_en = 1'b1;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       cnt_clr = 1'b0;

  logic       det_a, detq_a;
  logic [7:0] cnt_a;
  logic [3:0] pat_a;
  logic       det_b, detq_b;
  logic [1:0] cnt_b;
  logic [3:0] pat_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .PAT_INIT(4'b1101), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .detect(det_a), .detect_q(detq_a), .match_cnt(cnt_a), .pattern(pat_a)
  );

  seq_detector_param #(.PAT_W(4), .PAT_INIT(4'b1101), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .detect(det_b), .detect_q(detq_b), .match_cnt(cnt_b), .pattern(pat_b)
  );

  task automatic drive(input logic v, input logic b, input logic ld, input logic clr,
                       output logic det, output logic dq);
    @(negedge clk);
    dq = detq_a;
    din_valid = v;
    din = b;
    pat_load = ld;
    cnt_clr = clr;
    #1 det = det_a;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    din_valid = 1'b0;
    pat_load = 1'b0;
    cnt_clr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    total++; if (pat_a !== 4'b1101) begin bad++; $display("FAIL reset_pattern got=%b want=1101", pat_a); end
    total++; if (det_a !== 1'b0) begin bad++; $display("FAIL reset_detect got=%b want=0", det_a); end
    total++; if (detq_a !== 1'b0) begin bad++; $display("FAIL reset_detect_q got=%b want=0", detq_a); end
    total++; if (cnt_a !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt_a); end
    total++; if (cnt_b !== 2'd0) begin bad++; $display("FAIL reset_cnt_small got=%0d want=0", cnt_b); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_overlap();
    logic [9:0] bits;
    logic [9:0] exp;
    logic d, q;
    bits = 10'b1101101101;
    exp  = 10'b0001001001;
    do_reset();
    overlap_en = 1'b1;
    for (int i = 9; i >= 0; i--) begin
      drive(1'b1, bits[i], 1'b0, 1'b0, d, q);
      total++;
      if (d !== exp[i]) begin bad++; $display("FAIL overlap_detect bit%0d got=%b want=%b", 10 - i, d, exp[i]); end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, d, q);
    total++; if (cnt_a !== 8'd3) begin bad++; $display("FAIL overlap_cnt got=%0d want=3", cnt_a); end
  endtask

  task automatic test_non_overlap();
    logic [9:0] bits;
    logic [9:0] exp;
    logic d, q;
    bits = 10'b1101101101;
    exp  = 10'b0001000001;
    do_reset();
    overlap_en = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      drive(1'b1, bits[i], 1'b0, 1'b0, d, q);
      total++;
      if (d !== exp[i]) begin bad++; $display("FAIL nonoverlap_detect bit%0d got=%b want=%b", 10 - i, d, exp[i]); end
      if (i < 9) begin
        total++;
        if (q !== exp[i+1]) begin bad++; $display("FAIL nonoverlap_detect_q after bit%0d got=%b want=%b", 9 - i, q, exp[i+1]); end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, d, q);
    total++; if (q !== exp[0]) begin bad++; $display("FAIL nonoverlap_detect_q after bit10 got=%b want=%b", q, exp[0]); end
    total++; if (cnt_a !== 8'd2) begin bad++; $display("FAIL nonoverlap_cnt got=%0d want=2", cnt_a); end
  endtask

  task automatic test_stall();
    logic [6:0] v;
    logic [6:0] b;
    logic [6:0] exp;
    logic d, q;
    v   = 7'b1100011;
    b   = 7'b1111101;
    exp = 7'b0000001;
    do_reset();
    overlap_en = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      drive(v[i], b[i], 1'b0, 1'b0, d, q);
      total++;
      if (d !== exp[i]) begin bad++; $display("FAIL stall_detect step%0d got=%b want=%b", 7 - i, d, exp[i]); end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, d, q);
    total++; if (cnt_a !== 8'd1) begin bad++; $display("FAIL stall_cnt got=%0d want=1", cnt_a); end
  endtask

  task automatic test_saturate();
    logic [15:0] bits;
    logic [15:0] exp;
    logic d, q;
    bits = 16'b1101101101101101;
    exp  = 16'b0001001001001001;
    do_reset();
    overlap_en = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      drive(1'b1, bits[i], 1'b0, 1'b0, d, q);
      total++;
      if (d !== exp[i]) begin bad++; $display("FAIL sat_detect bit%0d got=%b want=%b", 16 - i, d, exp[i]); end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, d, q);
    total++; if (cnt_b !== 2'd3) begin bad++; $display("FAIL sat_cnt_small got=%0d want=3", cnt_b); end
    total++; if (cnt_a !== 8'd5) begin bad++; $display("FAIL sat_cnt_wide got=%0d want=5", cnt_a); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, d, q);
    drive(1'b1, 1'b0, 1'b0, 1'b0, d, q);
    drive(1'b1, 1'b1, 1'b0, 1'b1, d, q);
    total++; if (d !== 1'b1) begin bad++; $display("FAIL clr_cycle_detect got=%b want=1", d); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, d, q);
    total++; if (cnt_b !== 2'd0) begin bad++; $display("FAIL clr_cnt_small got=%0d want=0", cnt_b); end
    total++; if (cnt_a !== 8'd0) begin bad++; $display("FAIL clr_cnt_wide got=%0d want=0", cnt_a); end
  endtask

  task automatic test_pat_load();
    logic [3:0] s1;
    logic [3:0] e1;
    logic [3:0] s2;
    logic d, q;
    s1 = 4'b0110;
    e1 = 4'b0001;
    s2 = 4'b1101;
    do_reset();
    overlap_en = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, d, q);
    drive(1'b1, 1'b1, 1'b0, 1'b0, d, q);
    drive(1'b1, 1'b1, 1'b0, 1'b0, d, q);
    pat_in = 4'b0110;
    drive(1'b1, 1'b0, 1'b1, 1'b0, d, q);
    total++; if (d !== 1'b0) begin bad++; $display("FAIL load_cycle_detect got=%b want=0", d); end
    for (int i = 3; i >= 0; i--) begin
      drive(1'b1, s1[i], 1'b0, 1'b0, d, q);
      if (i == 3) begin
        total++;
        if (pat_a !== 4'b0110) begin bad++; $display("FAIL load_pattern got=%b want=0110", pat_a); end
      end
      total++;
      if (d !== e1[i]) begin bad++; $display("FAIL load_new_detect bit%0d got=%b want=%b", 4 - i, d, e1[i]); end
    end
    for (int i = 3; i >= 0; i--) begin
      drive(1'b1, s2[i], 1'b0, 1'b0, d, q);
      total++;
      if (d !== 1'b0) begin bad++; $display("FAIL load_old_detect bit%0d got=%b want=0", 4 - i, d); end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, d, q);
    total++; if (cnt_a !== 8'd1) begin bad++; $display("FAIL load_cnt got=%0d want=1", cnt_a); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] pre;
    logic [4:0] post;
    logic [4:0] exp;
    logic d, q;
    pre  = 3'b110;
    post = 5'b11101;
    exp  = 5'b00001;
    for (int i = 2; i >= 0; i--) begin
      drive(1'b1, pre[i], 1'b0, 1'b0, d, q);
      total++;
      if (d !== 1'b0) begin bad++; $display("FAIL mid_pre_detect bit%0d got=%b want=0", 3 - i, d); end
    end
    @(negedge clk);
    din_valid = 1'b1;
    din = 1'b1;
    #1;
    total++; if (cnt_a !== 8'd1) begin bad++; $display("FAIL mid_cnt_before got=%0d want=1", cnt_a); end
    reset = 1'b1;
    #1;
    total++; if (pat_a !== 4'b1101) begin bad++; $display("FAIL mid_reset_pattern got=%b want=1101", pat_a); end
    total++; if (det_a !== 1'b0) begin bad++; $display("FAIL mid_reset_detect got=%b want=0", det_a); end
    total++; if (cnt_a !== 8'd0) begin bad++; $display("FAIL mid_reset_cnt got=%0d want=0", cnt_a); end
    total++; if (detq_a !== 1'b0) begin bad++; $display("FAIL mid_reset_detect_q got=%b want=0", detq_a); end
    @(negedge clk);
    reset = 1'b0;
    din_valid = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      drive(1'b1, post[i], 1'b0, 1'b0, d, q);
      total++;
      if (d !== exp[i]) begin bad++; $display("FAIL mid_post_detect bit%0d got=%b want=%b", 5 - i, d, exp[i]); end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, d, q);
    total++; if (cnt_a !== 8'd1) begin bad++; $display("FAIL mid_post_cnt got=%0d want=1", cnt_a); end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_stall();
    test_saturate();
    test_pat_load();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed 4-bit Mealy 1101 detector.
- Pattern width is generic, the pattern is loadable at run time, overlap/non-overlap is selectable at run time, and input is qualified by a valid strobe.
- Provides an unregistered Mealy detect and a registered detect, plus a saturating match counter.
- Sits on a serial data stream ahead of framing/sync logic.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..32.
- PAT_INIT, 4'b1101 (PAT_W bits), pattern value after reset; MSB is the first bit received.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- din_valid  input  1  din is sampled on a rising clk edge only when this is 1.
- din  input  1  serial data bit.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every accepted bit.
- pat_load  input  1  load pat_in into the pattern register.
- pat_in  input  PAT_W  new pattern, MSB first.
- cnt_clr  input  1  synchronous clear of match_cnt.
- detect  output  1  Mealy match, combinational, same cycle as the completing bit.
- detect_q  output  1  registered detect, one cycle after detect.
- match_cnt  output  CNT_W  number of matches, saturating.
- pattern  output  PAT_W  current pattern register.

Behaviour:
- Reset (async, immediate):
  - hist = 0, fill = 0, pattern = PAT_INIT, detect_q = 0, match_cnt = 0.
  - detect = 0 while reset is high.
- State:
  - hist[PAT_W-2:0] holds the last PAT_W-1 accepted bits, newest in the LSB.
  - fill counts valid history bits, width $clog2(PAT_W), saturating at PAT_W-1.
- detect = din_valid & !pat_load & (fill == PAT_W-1) & ({hist, din} == pattern).
  - Purely combinational; no dependency on detect_q.
- Accepted bit (din_valid = 1, pat_load = 0) on a rising edge:
  - hist shifts left with din entering the LSB; the MSB drops off.
  - If detect and overlap_en = 0: hist = 0, fill = 0. The next match needs PAT_W fresh bits.
  - Otherwise fill = min(fill+1, PAT_W-1).
- No accepted bit (din_valid = 0): hist, fill and detect_q-source hold; detect = 0.
- pat_load = 1:
  - pattern = pat_in, hist = 0, fill = 0.
  - Any din in that cycle is discarded and detect = 0. pat_load wins over din_valid.
- detect_q is detect registered every clk edge, so it pulses exactly one cycle.
- match_cnt:
  - Increments on each cycle where detect = 1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr = 1 forces 0; if detect is also 1 that cycle, the result is 0 (clear wins).
- No match is possible until PAT_W bits have been accepted since reset, pattern load or a non-overlap match.
- A stall (din_valid = 0) between pattern bits does not break the match; only accepted bits count.
- Changing overlap_en mid-stream takes effect at the next accepted bit; history is not flushed.
- Reset asserted mid-pattern: the partial match is lost and the pattern returns to PAT_INIT.
- No X propagation:
  - All outputs are defined from reset.
  - The combinational block assigns every variable on every path, with blocking assignments only.
  - No state is written from the combinational block.

Decomposition:
- Package seq_det_pkg:
  - Constants OVERLAP = 1'b1 and NON_OVERLAP = 1'b0.
  - Function clog2.
  - Default pattern constant DEF_PAT_1101.
- Sub-module seq_hist_shift (PAT_W):
  - Owns the history shift register and fill counter.
  - Inputs: shift_en, bit_in, flush.
  - Outputs: hist and full (fill == PAT_W-1).
- The top level holds the pattern register, the compare, overlap control, detect_q and match_cnt.

Test Plan:
- Reset then default pattern 1101, overlap_en = 1, din_valid = 1, stream 1,1,0,1,1,0,1,1,0,1 → detect high on bits 4, 7, 10; match_cnt = 3.
- Same stream with overlap_en = 0 → detect on bits 4 and 10 only; match_cnt = 2; detect_q follows each detect by one cycle.
- Stream 1,1,0,1 with din_valid = 0 for 3 cycles between bits 2 and 3 → single detect on bit 4; detect = 0 during the stall cycles.
- pat_load with pat_in = 4'b0110, same cycle din_valid = 1 → pattern = 0110, that bit dropped; stream 0,1,1,0 → detect on the 4th bit; the old pattern 1101 no longer matches.
- CNT_W = 2, 5 overlapping matches of 1101 → match_cnt saturates at 3; cnt_clr asserted in a detect cycle → match_cnt = 0.
- reset asserted after bits 1,1,0 of 1101 → outputs 0 immediately; a following 1 does not detect; the full 1101 after release detects.
